// File: rtl/microcode_sequencer.sv
// Writable microcode store addressed by {instruction, micro_counter}; control_lines is combinational from the addressed word.
// Counter, instr_done and halted update on the clock edge; run=0 or halted freezes stepping, while store writes proceed regardless.
module microcode_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int STEP_W   = 2,
  parameter int CTRL_W   = 32,
  parameter logic [CTRL_W-1:0] ALWAYS_MASK = 32'h0000C860
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [OPCODE_W-1:0]          instruction,
  input  logic                         flags_valid,
  input  logic                         resume,
  input  logic                         ucode_we,
  input  logic [OPCODE_W+STEP_W-1:0]   ucode_waddr,
  input  logic [CTRL_W+1:0]            ucode_wdata,
  output logic [CTRL_W-1:0]            control_lines,
  output logic [STEP_W-1:0]            micro_counter,
  output logic                         instr_done,
  output logic                         halted
);

  localparam int ADDR_W   = OPCODE_W + STEP_W;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int END_BIT  = CTRL_W;
  localparam int HALT_BIT = CTRL_W + 1;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [CTRL_W+1:0]   store_q [DEPTH];
  logic [CTRL_W+1:0]   word;
  logic                last;

  // The store is deliberately left out of reset; software loads it before use.
  always_ff @(posedge clk) begin
    if (ucode_we) store_q[ucode_waddr] <= ucode_wdata;
  end

  assign word = store_q[{instruction, cnt_q}];
  assign last = word[END_BIT] || (cnt_q == {STEP_W{1'b1}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == ST_HALT) begin
      // Resume only leaves the halted state; stepping restarts on the next edge.
      if (resume) state_d = ST_RUN;
    end else if (run) begin
      if (last) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + STEP_W'(1);
      end
      if (word[HALT_BIT] && flags_valid) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    control_lines = '0;
    if (state_q == ST_RUN) begin
      control_lines = flags_valid ? word[CTRL_W-1:0] : (word[CTRL_W-1:0] & ALWAYS_MASK);
    end
  end

  assign micro_counter = cnt_q;
  assign instr_done    = done_q;
  assign halted        = (state_q == ST_HALT);

endmodule
